// File: rtl/mac_tile_reducer.sv
// Row-reduces MAC partial-sum tiles across COL_BLOCKS beats, requantizes each
// row total to a saturated fixed-point lane, and queues vectors in a small FIFO.
module mac_tile_reducer #(
    parameter int TILE_SIZE  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int FRAC_BITS  = 8,
    parameter int COL_BLOCKS = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [1:0]                                           mode,
    input  logic                                                 in_valid,
    input  logic signed [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0] in_tile,
    input  logic                                                 in_done_tile,
    output logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0]          out_vec,
    output logic                                                 out_valid,
    input  logic                                                 out_ready,
    input  logic                                                 err_clr,
    output logic                                                 frag_err,
    output logic                                                 sync_err,
    output logic                                                 overflow_err
);

    localparam int ROW_W = ACC_WIDTH + 2;
    localparam int SUM_W = ROW_W + $clog2(COL_BLOCKS);
    localparam int RQ_W  = SUM_W + 1;
    localparam int CNT_W = (COL_BLOCKS > 1) ? $clog2(COL_BLOCKS) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] MODE_MAC = 2'b00;
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCUM  = 1'b1;

    localparam logic signed [RQ_W-1:0] ROUND   = RQ_W'(2 ** (FRAC_BITS - 1));
    localparam logic signed [RQ_W-1:0] SAT_MAX = RQ_W'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [RQ_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef logic signed [DATA_WIDTH-1:0]    lane_t;
    typedef logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] vec_t;

    function automatic lane_t requant(input logic signed [SUM_W-1:0] acc);
        logic signed [RQ_W-1:0] v;
        lane_t                  res;
        v = (RQ_W'(acc) + ROUND) >>> FRAC_BITS;
        if (v > SAT_MAX)      res = SAT_MAX[DATA_WIDTH-1:0];
        else if (v < SAT_MIN) res = SAT_MIN[DATA_WIDTH-1:0];
        else                  res = v[DATA_WIDTH-1:0];
        return res;
    endfunction

    logic [0:0]              r_state;
    logic [CNT_W-1:0]        r_beat_cnt;
    logic signed [SUM_W-1:0] r_acc [TILE_SIZE];

    logic signed [ROW_W-1:0] w_rowsum [TILE_SIZE];
    logic signed [SUM_W-1:0] w_sum    [TILE_SIZE];
    vec_t                    w_push_vec;
    logic                    w_beat;
    logic                    w_last;
    logic                    w_frag_evt;

    assign w_beat     = in_valid && (mode == MODE_MAC);
    assign w_last     = w_beat &&
                        (((r_state == S_ACCUM) && (r_beat_cnt == CNT_W'(COL_BLOCKS - 1))) ||
                         ((r_state == S_IDLE) && (COL_BLOCKS == 1)));
    assign w_frag_evt = (r_state == S_ACCUM) && !w_beat;

    // The running sum starts from zero in IDLE, so one adder serves both the
    // first beat and every later one.
    always_comb begin
        // NOTE: every combinational output gets a value on every path so no latch is inferred.
        w_push_vec = '0;
        for (int r = 0; r < TILE_SIZE; r++) begin
            w_rowsum[r] = '0;
            for (int c = 0; c < TILE_SIZE; c++) begin
                w_rowsum[r] = w_rowsum[r] + ROW_W'($signed(in_tile[r][c]));
            end
            w_sum[r]      = ((r_state == S_ACCUM) ? r_acc[r] : '0) + SUM_W'(w_rowsum[r]);
            w_push_vec[r] = requant(w_sum[r]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_beat_cnt <= '0;
            for (int r = 0; r < TILE_SIZE; r++) r_acc[r] <= '0;
        end else if (w_last || !w_beat) begin
            r_state    <= S_IDLE;
            r_beat_cnt <= '0;
            for (int r = 0; r < TILE_SIZE; r++) r_acc[r] <= '0;
        end else begin
            r_state    <= S_ACCUM;
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            for (int r = 0; r < TILE_SIZE; r++) r_acc[r] <= w_sum[r];
        end
    end

    vec_t             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_pop;
    logic             w_full;
    logic             w_push_ok;
    logic             w_ovf_evt;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign out_valid = (r_level != '0);
    assign w_pop     = out_valid && out_ready;
    assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_push_ok = w_last && (!w_full || w_pop);
    assign w_ovf_evt = w_last && w_full && !w_pop;
    assign out_vec   = out_valid ? r_mem[r_rd_ptr] : '0;

    // NOTE: storage is deliberately not reset; out_vec is masked while empty so stale entries never show.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= w_push_vec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)     r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // A push event (kept or dropped) must be followed by exactly one done strobe.
    logic r_done_exp;
    logic w_sync_evt;

    assign w_sync_evt = (mode == MODE_MAC) && (in_done_tile != r_done_exp);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_exp   <= 1'b0;
            frag_err     <= 1'b0;
            sync_err     <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            r_done_exp   <= w_last;
            frag_err     <= (frag_err && !err_clr) || w_frag_evt;
            sync_err     <= (sync_err && !err_clr) || w_sync_evt;
            overflow_err <= (overflow_err && !err_clr) || w_ovf_evt;
        end
    end

endmodule

// File: tb/tb_mac_tile_reducer.sv
// Randomized and directed bench for mac_tile_reducer, scored against a
// cycle-level behavioural model built from integer arithmetic and a queue.
module tb_mac_tile_reducer;

    localparam int T  = 4;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int FB = 8;
    localparam int CB = 16;
    localparam int FD = 2;

    typedef logic [T-1:0][DW-1:0] vec_t;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [1:0]                   mode;
    logic                         in_valid;
    logic [T-1:0][T-1:0][AW-1:0]  in_tile;
    logic                         in_done_tile;
    vec_t                         out_vec;
    logic                         out_valid;
    logic                         out_ready;
    logic                         err_clr;
    logic                         frag_err;
    logic                         sync_err;
    logic                         overflow_err;

    always #5 clk = ~clk;

    mac_tile_reducer #(
        .TILE_SIZE (T),
        .DATA_WIDTH(DW),
        .ACC_WIDTH (AW),
        .FRAC_BITS (FB),
        .COL_BLOCKS(CB),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .in_valid    (in_valid),
        .in_tile     (in_tile),
        .in_done_tile(in_done_tile),
        .out_vec     (out_vec),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err_clr     (err_clr),
        .frag_err    (frag_err),
        .sync_err    (sync_err),
        .overflow_err(overflow_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a run of CB consecutive MAC beats yields one vector.
    longint m_sum [T];
    int     m_run;
    vec_t   m_q [$];
    bit     m_dexp, m_frag, m_sync, m_ovf;
    bit     auto_done;
    bit     last_rst;

    function automatic logic [DW-1:0] requant_m(input longint v);
        longint q;
        longint hi;
        hi = (longint'(1) << (DW - 1)) - 1;
        q  = (v + (longint'(1) << (FB - 1))) >>> FB;
        if (q > hi)          q = hi;
        else if (q < -hi - 1) q = -hi - 1;
        return DW'(q);
    endfunction

    function automatic vec_t splat(input logic [DW-1:0] x);
        vec_t v;
        for (int r = 0; r < T; r++) v[r] = x;
        return v;
    endfunction

    task automatic model_edge();
        bit   beat, push, pop, sync_ev, frag_ev, ovf_ev;
        vec_t v;
        longint s;
        last_rst = rst;
        if (rst) begin
            m_q.delete();
            for (int r = 0; r < T; r++) m_sum[r] = 0;
            m_run = 0;
            m_dexp = 0; m_frag = 0; m_sync = 0; m_ovf = 0;
            return;
        end
        beat    = in_valid && (mode == 2'b00);
        push    = 0;
        v       = '0;
        sync_ev = (mode == 2'b00) && (in_done_tile != m_dexp);
        frag_ev = (m_run > 0) && !beat;
        if (beat) begin
            for (int r = 0; r < T; r++) begin
                s = 0;
                for (int c = 0; c < T; c++) s += longint'($signed(in_tile[r][c]));
                m_sum[r] += s;
            end
            m_run++;
            if (m_run == CB) begin
                push = 1;
                for (int r = 0; r < T; r++) begin
                    v[r] = requant_m(m_sum[r]);
                    m_sum[r] = 0;
                end
                m_run = 0;
            end
        end else begin
            for (int r = 0; r < T; r++) m_sum[r] = 0;
            m_run = 0;
        end
        pop    = (m_q.size() != 0) && out_ready;
        ovf_ev = push && (m_q.size() == FD) && !pop;
        if (pop) void'(m_q.pop_front());
        if (push && !ovf_ev) m_q.push_back(v);
        m_dexp = push;
        m_frag = (m_frag && !err_clr) || frag_ev;
        m_sync = (m_sync && !err_clr) || sync_ev;
        m_ovf  = (m_ovf && !err_clr) || ovf_ev;
    endtask

    task automatic step();
        if (auto_done) in_done_tile = m_dexp;
        @(posedge clk);
        model_edge();
        #1;
        check("out_valid", out_valid, m_q.size() != 0);
        if (m_q.size() != 0)  check("out_vec", out_vec, m_q[0]);
        else if (last_rst)    check("out_vec_rst", out_vec, 64'd0);
        check("frag_err", frag_err, m_frag);
        check("sync_err", sync_err, m_sync);
        check("overflow_err", overflow_err, m_ovf);
    endtask

    task automatic fill(input logic [AW-1:0] x);
        for (int r = 0; r < T; r++)
            for (int c = 0; c < T; c++) in_tile[r][c] = x;
    endtask

    task automatic beats(input int n, input logic [AW-1:0] x);
        in_valid = 1'b1;
        mode     = 2'b00;
        fill(x);
        repeat (n) step();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        mode     = 2'b00;
        fill('0);
        repeat (n) step();
    endtask

    task automatic lane_vector(input int k);
        in_valid = 1'b1;
        mode     = 2'b00;
        fill('0);
        for (int r = 0; r < T; r++) in_tile[r][0] = AW'(k * 256);
        step();
        fill('0);
        repeat (CB - 1) step();
    endtask

    task automatic clear_errors();
        in_valid = 1'b0;
        err_clr  = 1'b1;
        step();
        err_clr  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mode = 2'b00; in_valid = 1'b0; fill('0);
        in_done_tile = 1'b0; out_ready = 1'b1; err_clr = 1'b0; auto_done = 1'b1;
        m_run = 0;
        for (int r = 0; r < T; r++) m_sum[r] = 0;
        step(); step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_vec", out_vec, 0);
        rst = 1'b0;

        // Unity weights: 16 x 4 x 1.0 = 64 per lane, visible the cycle after the last beat.
        beats(CB, 32'd256);
        check("unity_latency", out_valid, 1);
        check("unity_vec", out_vec, splat(16'd64));
        idle(2);
        check("unity_flags", {frag_err, sync_err, overflow_err}, 3'b000);

        // -1.5 rounds half up to -1.
        in_valid = 1'b1; fill('0); in_tile[0][0] = -32'sd384;
        step();
        fill('0);
        repeat (CB - 1) step();
        check("round_vec", out_vec, 64'h0000_0000_0000_FFFF);
        idle(2);

        beats(CB, 32'h0010_0000);
        check("sat_pos", out_vec, splat(16'h7FFF));
        idle(1);
        beats(CB, 32'hFFF0_0000);
        check("sat_neg", out_vec, splat(16'h8000));
        idle(2);

        // Fragmented run is dropped, the clean run that follows is kept.
        beats(5, 32'd256);
        idle(1);
        check("frag_set", frag_err, 1);
        beats(CB, 32'd256);
        check("frag_clean_vec", out_vec, splat(16'd64));
        idle(2);
        check("frag_one_vec", out_valid, 0);
        clear_errors();
        check("frag_cleared", frag_err, 0);

        // Three vectors into a two-entry FIFO with the consumer stalled.
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) lane_vector(k);
        check("ovf_set", overflow_err, 1);
        check("ovf_head1", out_vec, splat(16'd1));
        out_ready = 1'b1;
        idle(1);
        check("ovf_head2", out_vec, splat(16'd2));
        idle(1);
        check("ovf_third_lost", out_valid, 0);
        clear_errors();
        check("ovf_cleared", overflow_err, 0);

        // Reset mid-run discards the partial sum.
        beats(7, 32'd256);
        rst = 1'b1;
        step();
        rst = 1'b0;
        beats(CB, 32'd256);
        check("rst_mid_vec", out_vec, splat(16'd64));
        idle(2);
        check("rst_mid_one_vec", out_valid, 0);
        check("rst_mid_flags", {frag_err, sync_err, overflow_err}, 3'b000);

        // Early done strobe.
        beats(2, 32'd256);
        auto_done = 1'b0; in_done_tile = 1'b1;
        beats(1, 32'd256);
        auto_done = 1'b1;
        check("sync_set", sync_err, 1);
        beats(CB - 3, 32'd256);
        idle(2);
        clear_errors();
        check("sync_cleared", sync_err, 0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            in_valid = ($urandom_range(0, 99) < 96);
            mode     = ($urandom_range(0, 99) < 97) ? 2'b00 : 2'($urandom_range(1, 3));
            for (int r = 0; r < T; r++)
                for (int c = 0; c < T; c++)
                    in_tile[r][c] = ($urandom_range(0, 3) == 0) ? 32'($urandom())
                                                                 : 32'($urandom_range(0, 8191)) - 32'd4096;
            out_ready = ($urandom_range(0, 99) < 60);
            err_clr   = ($urandom_range(0, 99) < 4);
            rst       = ($urandom_range(0, 999) < 5);
            auto_done = ($urandom_range(0, 99) >= 3);
            if (!auto_done) in_done_tile = 1'($urandom_range(0, 1));
            step();
        end
        rst = 1'b0; err_clr = 1'b0; auto_done = 1'b1; out_ready = 1'b1;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
